pixel_stream_gen: RTL and testbench

Synthesizable frame source clocked and reset by the bench clock/reset generator. It sits directly downstream of that generator and upstream of the CNN input port. After a programmable post-reset settle delay it emits NUM_FRAMES deterministic IMG_W x IMG_H frames over a valid/ready stream, with start/end-of-line/end-of-frame markers. The CNN datapath is exercised without file I/O.

---
 rtl/pixel_stream_gen.sv | 137 +++++++++++++
 tb/tb_pixel_stream_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_gen.sv
// Deterministic frame source: after a settle delay it streams NUM_FRAMES IMG_W x IMG_H frames
// with sof/eol/eof markers. Define PIXEL_STREAM_GEN_LFSR_EN for LFSR pixel data instead of a ramp.
module pixel_stream_gen #(
    parameter int DATA_W      = 8,
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int START_DELAY = 16,
    parameter int NUM_FRAMES  = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    output logic [DATA_W-1:0]                 data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              sof_o,
    output logic                              eol_o,
    output logic                              eof_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_idx_o
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int FRM_W = $clog2(NUM_FRAMES + 1);
    localparam int DLY_W = $clog2(START_DELAY + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    // Handshake: a pixel moves on a rising edge where valid_o && ready_i; while valid_o is
    // high and ready_i low, data and markers hold because the counters only move on a transfer.
    logic [1:0]       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [DLY_W-1:0] dly_cnt;
    logic [DATA_W-1:0] pixel;
    logic             xfer;
    logic             start_ok;
    logic             last_col;
    logic             last_row;
    logic             last_frame;

    assign valid_o  = (state == ST_STREAM);
    assign busy_o   = (state == ST_WAIT) || (state == ST_STREAM);
    assign xfer     = valid_o && ready_i;
    // A start that coincides with the done pulse belongs to the run that just ended.
    assign start_ok = (state == ST_IDLE) && start_i && !done_o;

    assign last_col   = (col == COL_W'(IMG_W - 1));
    assign last_row   = (row == ROW_W'(IMG_H - 1));
    assign last_frame = (frame_idx_o == FRM_W'(NUM_FRAMES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            col         <= '0;
            row         <= '0;
            frame_idx_o <= '0;
            dly_cnt     <= '0;
            done_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state       <= ST_WAIT;
                        dly_cnt     <= '0;
                        col         <= '0;
                        row         <= '0;
                        frame_idx_o <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dly_cnt == DLY_W'(START_DELAY - 1)) begin
                        state <= ST_STREAM;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) begin
                                row <= '0;
                                // frame_idx_o keeps the final frame number while idle.
                                if (last_frame) begin
                                    state  <= ST_IDLE;
                                    done_o <= 1'b1;
                                end else begin
                                    frame_idx_o <= frame_idx_o + 1'b1;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PIXEL_STREAM_GEN_LFSR_EN
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic        lfsr_fb;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 in a right-shifting register.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr <= LFSR_SEED;
        end else if (start_ok) begin
            lfsr <= LFSR_SEED;
        end else if (xfer) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end

    assign pixel = lfsr[DATA_W-1:0];
`else
    assign pixel = DATA_W'(32'(row) * 32'(IMG_W) + 32'(col) + 32'(frame_idx_o));
`endif

    assign data_o = valid_o ? pixel : '0;
    assign sof_o  = valid_o && (row == '0) && (col == '0);
    assign eol_o  = valid_o && last_col;
    assign eof_o  = valid_o && last_col && last_row;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Bench for pixel_stream_gen: a transaction-level model (queue of expected pixels, delay and
// done timing) is compared against the DUT every cycle; literal checks pin the model.
module tb_pixel_stream_gen;
    localparam int DATA_W      = 3;
    localparam int IMG_W       = 4;
    localparam int IMG_H       = 3;
    localparam int START_DELAY = 4;
    localparam int NUM_FRAMES  = 2;
    localparam int FW          = $clog2(NUM_FRAMES + 1);
    localparam int NPIX        = IMG_W * IMG_H * NUM_FRAMES;
    localparam int EW          = FW + 3 + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              busy;
    logic              done;
    logic [FW-1:0]     frame_idx;

    pixel_stream_gen #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .START_DELAY(START_DELAY), .NUM_FRAMES(NUM_FRAMES)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .data_o(data), .valid_o(valid),
        .ready_i(ready), .sof_o(sof), .eol_o(eol), .eof_o(eof), .busy_o(busy),
        .done_o(done), .frame_idx_o(frame_idx)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [EW-1:0]     exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  n_xfer = 0;
    int  n_done = 0;
    int  acc_cyc = 0;
    int  done_cyc = 0;
    int  first_valid_cyc = 0;
    bit  seen_valid = 0;
    bit  mon_en = 0;
    bit  run_active = 0;
    int  wait_left = 0;
    bit  done_exp = 0;
    logic [FW-1:0] frame_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected transfer sequence for one run: {frame, eof, eol, sof, data}.
    task automatic fill_run();
        logic [15:0]       s;
        logic [DATA_W-1:0] d;
        s = 16'hACE1;
        exp_q.delete();
        for (int f = 0; f < NUM_FRAMES; f++) begin
            for (int r = 0; r < IMG_H; r++) begin
                for (int c = 0; c < IMG_W; c++) begin
`ifdef PIXEL_STREAM_GEN_LFSR_EN
                    d = s[DATA_W-1:0];
                    s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
`else
                    d = DATA_W'((r * IMG_W + c + f) % (1 << DATA_W));
`endif
                    exp_q.push_back({FW'(f), (r == IMG_H - 1) && (c == IMG_W - 1),
                                     c == IMG_W - 1, (r == 0) && (c == 0), d});
                end
            end
        end
    endtask

    // ---------------- compare process ----------------
    initial begin : monitor
        logic [EW-1:0] front;
        logic [EW-1:0] head;
        logic          exp_valid;
        logic          nxt_done;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_valid = run_active && (wait_left == 0) && (exp_q.size() > 0);
                front = exp_valid ? exp_q[0] : '0;
                chk("valid_o", 32'(valid), 32'(exp_valid));
                chk("busy_o", 32'(busy), 32'(run_active));
                chk("done_o", 32'(done), 32'(done_exp));
                chk("frame_idx_o", 32'(frame_idx), 32'(frame_exp));
                chk("data_o", 32'(data), 32'(front[DATA_W-1:0]));
                chk("sof_o", 32'(sof), 32'(front[DATA_W]));
                chk("eol_o", 32'(eol), 32'(front[DATA_W+1]));
                chk("eof_o", 32'(eof), 32'(front[DATA_W+2]));

                if (valid && ready) begin
                    got_q.push_back(data);
                    n_xfer++;
                end
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
                if (valid && !seen_valid) begin
                    seen_valid = 1;
                    first_valid_cyc = cyc;
                end

                // Advance the model to what the coming rising edge must produce.
                nxt_done = 1'b0;
                if (rst) begin
                    run_active = 0;
                    wait_left = 0;
                    exp_q.delete();
                    frame_exp = '0;
                end else if (run_active) begin
                    if (wait_left > 0) begin
                        wait_left--;
                    end else if (ready) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            run_active = 0;
                            nxt_done = 1'b1;
                        end else begin
                            head = exp_q[0];
                            frame_exp = head[EW-1:DATA_W+3];
                        end
                    end
                end else if (start && !done_exp) begin
                    run_active = 1;
                    wait_left = START_DELAY;
                    fill_run();
                    frame_exp = '0;
                    acc_cyc = cyc;
                end
                done_exp = nxt_done;
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int k;
        k = 0;
        while (n_xfer < target && k < budget) begin
            tick();
            k++;
        end
        chk("wait_xfer_timeout", 32'(n_xfer >= target), 32'd1);
    endtask

    task automatic wait_done(input int base, input int budget);
        int k;
        k = 0;
        while (n_done == base && k < budget) begin
            tick();
            k++;
        end
        chk("wait_done_timeout", 32'(n_done != base), 32'd1);
    endtask

    task automatic check_literal_run();
        logic [DATA_W-1:0] lit [NPIX];
        lit = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3,
                3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        chk("pixel_count", 32'(got_q.size()), 32'd24);
`ifndef PIXEL_STREAM_GEN_LFSR_EN
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            chk("ramp_literal", 32'(got_q[i]), 32'(lit[i]));
        end
`else
        if (got_q.size() > 0) chk("lfsr_first", 32'(got_q[0]), 32'h1);
`endif
    endtask

    // Full run with ready held high; optionally pokes start during WAIT, STREAM and done.
    task automatic run_basic(input bit poke);
        int base_done;
        int base_xfer;
        int k;
        got_q.delete();
        seen_valid = 0;
        base_done = n_done;
        base_xfer = n_xfer;
        ready = 1'b1;
        pulse_start();
        if (poke) begin
            tick();
            tick();
            pulse_start();
            wait_xfer(base_xfer + 6, 200);
            pulse_start();
            k = 0;
            while (cyc < acc_cyc + START_DELAY + 1 + NPIX && k < 200) begin
                tick();
                k++;
            end
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(base_done, 400);
        chk("first_valid_latency", 32'(first_valid_cyc - acc_cyc), 32'd5);
        chk("done_cycle", 32'(done_cyc - acc_cyc), 32'd29);
        check_literal_run();
        repeat (4) tick();
        chk("done_once", 32'(n_done - base_done), 32'd1);
        chk("idle_after_run", 32'(busy), 32'd0);
        chk("frame_idx_held", 32'(frame_idx), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DATA_W-1:0] held;
        int base_done;
        int base_xfer;
        int k;
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        tick();
        mon_en = 1;
        tick();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_frame", 32'(frame_idx), 32'd0);
        chk("reset_data", 32'(data), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        run_basic(1'b0);
        run_basic(1'b1);

        // Backpressure while pixel 5 is presented.
        got_q.delete();
        base_done = n_done;
        base_xfer = n_xfer;
        ready = 1'b1;
        pulse_start();
        wait_xfer(base_xfer + 5, 200);
        ready = 1'b0;
        held = data;
`ifndef PIXEL_STREAM_GEN_LFSR_EN
        chk("stall_pixel", 32'(held), 32'd5);
`endif
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", 32'(valid), 32'd1);
            chk("stall_data", 32'(data), 32'(held));
            tick();
        end
        ready = 1'b1;
        tick();
        wait_done(base_done, 400);
        check_literal_run();

        // Reset during row 1, then a clean restart.
        base_xfer = n_xfer;
        ready = 1'b1;
        pulse_start();
        wait_xfer(base_xfer + 5, 200);
        rst = 1'b1;
        tick();
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_frame", 32'(frame_idx), 32'd0);
        chk("midrst_sof", 32'(sof), 32'd0);
        rst = 1'b0;
        tick();
        run_basic(1'b0);

        // Random ready and stray start pulses.
        for (int r = 0; r < 6; r++) begin
            base_done = n_done;
            got_q.delete();
            repeat ($urandom_range(0, 5)) begin
                ready = 1'($urandom_range(0, 1));
                tick();
            end
            pulse_start();
            k = 0;
            while (n_done == base_done && k < 3000) begin
                ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 9) == 0);
                tick();
                k++;
            end
            start = 1'b0;
            chk("random_run_done", 32'(n_done != base_done), 32'd1);
            repeat (2) tick();
            chk("random_run_count", 32'(got_q.size()), 32'(NPIX));
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
